// File: rtl/ctrl_mem_arb.sv
// RAM arbiter between instruction fetch and MEM-stage LDR/STR, with stall.
// Optional ack watchdog enabled by defining CTRL_MEM_ARB_TIMEOUT_EN.
module ctrl_mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic [DW-1:0] o_if_data,
  output logic          o_if_valid,
  input  logic [15:0]   i_ir_mem,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_wdata,
  output logic [DW-1:0] o_mem_rdata,
  output logic          o_mem_valid,
  output logic          o_stall,
  output logic          o_ram_req,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata,
  input  logic          i_ram_ack,
  output logic          o_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FETCH
  } state_t;

  state_t state_q, state_d;

  logic [4:0] op;
  logic       is_ldr;
  logic       is_str;
  logic       data_need;
  logic       data_done;
  logic       if_done;
  logic       data_pend;
  logic       if_pend;
  logic       data_end;
  logic       fetch_end;
  logic       tmo;
  logic       unused_bits;

  assign op        = i_ir_mem[15:11];
  assign is_ldr    = (op == 5'b01101);
  assign is_str    = (op == 5'b01110);
  assign data_need = is_ldr | is_str;
  assign data_pend = data_need & ~data_done;
  assign if_pend   = i_if_req & ~if_done;
  assign o_stall   = data_pend | if_pend;

  assign unused_bits = ^{i_ir_mem[10:0], TIMEOUT[0]};

`ifdef CTRL_MEM_ARB_TIMEOUT_EN
  logic [15:0] cnt;

  // ack in the same cycle wins over the watchdog
  assign tmo = (state_q != IDLE) & ~i_ram_ack
             & (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      o_err <= 1'b0;
    end else begin
      o_err <= tmo;
      if (state_d != state_q)
        cnt <= '0;
      else if (state_q != IDLE && !i_ram_ack)
        cnt <= cnt + 16'd1;
    end
  end
`else
  assign tmo   = 1'b0;
  assign o_err = 1'b0;
`endif

  assign data_end  = (state_q == DATA)  & (i_ram_ack | tmo);
  assign fetch_end = (state_q == FETCH) & (i_ram_ack | tmo);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (data_pend)    state_d = DATA;
        else if (if_pend) state_d = FETCH;
      end
      DATA: begin
        if (i_ram_ack) state_d = if_pend ? FETCH : IDLE;
        else if (tmo)  state_d = IDLE;
      end
      FETCH: begin
        if (i_ram_ack) state_d = data_pend ? DATA : IDLE;
        else if (tmo)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      o_ram_req   <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      o_if_data   <= '0;
      o_if_valid  <= 1'b0;
      o_mem_rdata <= '0;
      o_mem_valid <= 1'b0;
      data_done   <= 1'b0;
      if_done     <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_if_valid  <= fetch_end;
      o_mem_valid <= data_end;

      // RAM outputs are captured on entry and held until completion
      if (state_d == DATA && state_q != DATA) begin
        o_ram_req   <= 1'b1;
        o_ram_we    <= is_str;
        o_ram_addr  <= i_mem_addr;
        o_ram_wdata <= i_mem_wdata;
      end else if (state_d == FETCH && state_q != FETCH) begin
        o_ram_req  <= 1'b1;
        o_ram_we   <= 1'b0;
        o_ram_addr <= i_if_addr;
      end else if (state_d == IDLE) begin
        o_ram_req <= 1'b0;
        o_ram_we  <= 1'b0;
      end

      if (data_end) begin
        if (!i_ram_ack)  o_mem_rdata <= '0;
        else if (is_ldr) o_mem_rdata <= i_ram_rdata;
      end

      if (fetch_end)
        o_if_data <= i_ram_ack ? i_ram_rdata : '0;

      if (!o_stall) begin
        data_done <= 1'b0;
        if_done   <= 1'b0;
      end else begin
        if (data_end)  data_done <= 1'b1;
        if (fetch_end) if_done   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ctrl_mem_arb.md
Name: ctrl_mem_arb

Overview:
- Arbitrates the single-port data/instruction RAM between instruction fetch (IF) and the memory stage (LDR/STR in MEM).
- Decodes the MEM-stage instruction register and sequences RAM request/ack handshakes.
- Returns read data to the requester and drives the pipeline-wide stall until every pending access has completed.
- Sits between the pipeline control blocks (ctrl_* decoders) and the RAM wrapper.

Parameters:
AW, 16, address width
DW, 16, data width
TIMEOUT, 255, ack watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
i_if_req  in  1  fetch wants an instruction word
i_if_addr  in  AW  fetch address (PC)
o_if_data  out  DW  fetched word, registered
o_if_valid  out  1  one-cycle pulse: o_if_data updated
i_ir_mem  in  16  MEM-stage instruction register
i_mem_addr  in  AW  load/store address
i_mem_wdata  in  DW  store data
o_mem_rdata  out  DW  load data, registered
o_mem_valid  out  1  one-cycle pulse: load/store completed
o_stall  out  1  freeze pipeline
o_ram_req  out  1  RAM request, held until ack
o_ram_we  out  1  1 = write
o_ram_addr  out  AW  RAM address
o_ram_wdata  out  DW  RAM write data
i_ram_rdata  in  DW  RAM read data, valid with ack
i_ram_ack  in  1  RAM completes the request this cycle
o_err  out  1  one-cycle pulse: access aborted by timeout

Behaviour:
- Decode uses i_ir_mem[15:11].
  - 5'b01101 = LDR (read).
  - 5'b01110 = STR (write).
  - All other opcodes: no data access.
- data_need = decoded LDR or STR.
- Flags: data_done and if_done, one per requester.
  - Each is set on completion of its access.
  - Both clear at any clock edge where o_stall = 0 (pipeline advances).
- o_stall is combinational: (data_need & ~data_done) | (i_if_req & ~if_done).
- FSM states:
  - IDLE: o_ram_req = 0.
    - data_need & ~data_done -> DATA.
    - Else i_if_req & ~if_done -> FETCH.
    - Else stay.
    - MEM has priority over IF.
  - DATA: RAM outputs registered on entry.
    - o_ram_req = 1, o_ram_we = STR, o_ram_addr = i_mem_addr, o_ram_wdata = i_mem_wdata.
    - Outputs are held stable until ack.
  - FETCH: o_ram_req = 1, o_ram_we = 0, o_ram_addr = i_if_addr.
- On i_ram_ack in DATA, at the same edge:
  - o_ram_req drops.
  - LDR: o_mem_rdata <= i_ram_rdata. STR: o_mem_rdata unchanged.
  - o_mem_valid pulses for one cycle; data_done is set.
  - Next state is FETCH if i_if_req & ~if_done (no idle bubble), else IDLE.
- On i_ram_ack in FETCH:
  - o_if_data <= i_ram_rdata; o_if_valid pulses; if_done is set.
  - Next state is DATA if data_need & ~data_done, else IDLE.
- Minimum latency with ack in the first request cycle:
  - Request seen in IDLE, cycle N.
  - o_ram_req high, cycle N+1.
  - valid pulse and stall release, cycle N+2.
- i_ram_ack outside DATA/FETCH is ignored.
- A new i_ir_mem while the request is outstanding cannot occur because o_stall holds the pipeline; no requirement is placed on that case.
- Reset (rst = 0 at an edge, including mid-access):
  - State returns to IDLE; o_ram_req, o_ram_we, o_if_valid, o_mem_valid and o_err go to 0.
  - Data/address outputs go to 0; done flags clear.
  - Any in-flight RAM access is abandoned.

Optional Feature:
CTRL_MEM_ARB_TIMEOUT_EN
- Defined:
  - An 8..16-bit counter clears on entering DATA/FETCH and increments each cycle without ack.
  - When it reaches TIMEOUT, at that edge: o_ram_req drops, o_err pulses one cycle, the matching valid pulses with data = 0, the done flag sets, and the FSM goes to IDLE.
  - An ack arriving in the same cycle as the timeout takes precedence (normal completion, no o_err).
- Undefined: the FSM waits indefinitely and o_err is tied to 0.

Test Plan:
- Reset: rst = 0 for 2 cycles during FETCH with o_ram_req = 1 -> all outputs 0, state IDLE, o_stall = i_if_req.
- Fetch only: i_if_req = 1, i_if_addr = 0x0040, ir = NOP, ack one cycle after req with rdata = 0x6A05 -> o_if_data = 0x6A05, o_if_valid single pulse, o_stall low the same cycle.
- Load plus fetch together: ir = 0x6800 (LDR), addr 0x0100, and i_if_req = 1 -> DATA first, then FETCH back-to-back with no IDLE cycle; o_mem_rdata = 0xBEEF, then o_if_data = 0x1234; o_stall low only after both complete.
- Store: ir = 0x7000 (STR), addr 0x0200, wdata 0x00FF, ack after 3 wait cycles -> o_ram_we = 1 with address/data held stable for 4 cycles; o_mem_valid pulses; o_mem_rdata unchanged.
- Non-memory opcode 0x2000 with i_if_req = 0 -> o_ram_req never asserts, o_stall = 0.
- With CTRL_MEM_ARB_TIMEOUT_EN and TIMEOUT = 4: LDR with ack never given -> o_err pulses 4 cycles after the request starts, o_mem_rdata = 0, FSM returns to IDLE, stall releases.
